// File: rtl/uart_rx_cmd_ctrl_if.sv
// Byte-stream and status bundle between the UART receiver side and the
// command sequencer. The receiver side is the master: it supplies bytes
// and observes the LED and status outputs.
interface uart_rx_cmd_ctrl_if #(
  parameter int ERR_W = 4
);
  logic [7:0]       rx_data;
  logic             rx_ready;
  logic             rx_error;
  logic [15:0]      led;
  logic             busy;
  logic             cmd_done;
  logic             cmd_err;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output rx_data, rx_ready, rx_error,
    input  led, busy, cmd_done, cmd_err, err_cnt
  );

  modport slave (
    input  rx_data, rx_ready, rx_error,
    output led, busy, cmd_done, cmd_err, err_cnt
  );
endinterface

// File: rtl/uart_rx_cmd_ctrl.sv
// Command sequencer behind the UART receiver. Turns each rising edge of
// rx_ready into one byte, parses 1-byte opcodes and the 3-byte load frame,
// and drives a 16-bit LED register. Receiver errors and inter-byte
// timeouts abort the frame and bump a saturating error counter.
module uart_rx_cmd_ctrl #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int ERR_W          = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_rx_cmd_ctrl_if.slave  bus
);

  // Timer only needs to reach TIMEOUT_CYCLES-1.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]    T_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  localparam logic [7:0] OP_LOAD = 8'h4C;
  localparam logic [7:0] OP_CLR  = 8'h43;
  localparam logic [7:0] OP_INC  = 8'h49;
  localparam logic [7:0] OP_ROT  = 8'h44;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GET_HI = 2'd1,
    GET_LO = 2'd2
  } state_t;

  state_t           state;
  logic [TW-1:0]    timer;
  logic [7:0]       hi_q;
  logic             rdy_q;
  logic [15:0]      led_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [ERR_W-1:0] err_cnt_q;

  logic byte_stb;
  logic bad_opcode;
  logic timeout_hit;
  logic raise_err;

  assign byte_stb = bus.rx_ready & ~rdy_q;

  // Classify this cycle's abort conditions; a byte strobe always beats the timeout.
  always_comb begin
    bad_opcode  = 1'b0;
    timeout_hit = 1'b0;
    if (state == IDLE) begin
      bad_opcode = (bus.rx_data != OP_LOAD) && (bus.rx_data != OP_CLR) &&
                   (bus.rx_data != OP_INC)  && (bus.rx_data != OP_ROT);
    end
    if (state != IDLE) begin
      timeout_hit = (timer == T_LAST);
    end
    raise_err = byte_stb ? (bus.rx_error | bad_opcode) : timeout_hit;
  end

  // Frame parser, LED register, timeout timer and error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      hi_q      <= '0;
      rdy_q     <= 1'b1;
      led_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      rdy_q  <= bus.rx_ready;
      done_q <= 1'b0;
      err_q  <= raise_err;

      if (raise_err && (err_cnt_q != ERR_MAX)) begin
        err_cnt_q <= err_cnt_q + ERR_W'(1);
      end

      if (byte_stb) begin
        timer <= '0;
        if (bus.rx_error) begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end else begin
          case (state)
            IDLE: begin
              case (bus.rx_data)
                OP_LOAD: begin
                  state  <= GET_HI;
                  busy_q <= 1'b1;
                end
                OP_CLR: begin
                  led_q  <= '0;
                  done_q <= 1'b1;
                end
                OP_INC: begin
                  led_q  <= led_q + 16'd1;
                  done_q <= 1'b1;
                end
                OP_ROT: begin
                  led_q  <= {led_q[14:0], led_q[15]};
                  done_q <= 1'b1;
                end
                default: ;
              endcase
            end
            GET_HI: begin
              hi_q   <= bus.rx_data;
              state  <= GET_LO;
              busy_q <= 1'b1;
            end
            GET_LO: begin
              led_q  <= {hi_q, bus.rx_data};
              done_q <= 1'b1;
              state  <= IDLE;
              busy_q <= 1'b0;
            end
            default: begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          endcase
        end
      end else if (state == IDLE) begin
        timer <= '0;
      end else if (timeout_hit) begin
        timer  <= '0;
        state  <= IDLE;
        busy_q <= 1'b0;
      end else begin
        timer <= timer + TW'(1);
      end
    end
  end

  assign bus.led      = led_q;
  assign bus.busy     = busy_q;
  assign bus.cmd_done = done_q;
  assign bus.cmd_err  = err_q;
  assign bus.err_cnt  = err_cnt_q;

endmodule
